// File: rtl/cv32e40p_ft_manager.sv
// rtl/cv32e40p_ft_manager.sv - fault-tolerance status collector, error counters, sticky flags and register port
module cv32e40p_ft_manager #(
    parameter int N_BLOCKS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_BLOCKS-1:0]     err_detected_i,
    input  logic [N_BLOCKS-1:0]     err_corrected_i,
    input  logic [3*N_BLOCKS-1:0]   is_broken_i,
    output logic [3*N_BLOCKS-1:0]   set_broken_o,
    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [3:0]              cfg_addr_i,
    input  logic [31:0]             cfg_wdata_i,
    output logic                    cfg_rvalid_o,
    output logic [31:0]             cfg_rdata_o,
    output logic                    irq_o
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_UNCORR = 4'h1;
    localparam logic [3:0] ADDR_NEWBRK = 4'h2;
    localparam logic [3:0] ADDR_BROKEN = 4'h3;
    localparam logic [3:0] ADDR_FORCE  = 4'h4;

    state_t                    state_q, state_d;
    logic [1:0]                ctrl_q;
    logic [N_BLOCKS-1:0]       uncorr_q, newbrk_q;
    logic [N_BLOCKS-1:0]       uncorr_set, newbrk_set;
    logic [N_BLOCKS-1:0]       uncorr_clr, newbrk_clr;
    logic [3*N_BLOCKS-1:0]     force_q, brk_q;
    logic [N_BLOCKS*CNT_W-1:0] cnt_flat;
    logic [31:0]               rdata_d, rdata_q;
    logic                      wr_en, rd_en;
    logic                      unused_wdata;

    assign wr_en        = cfg_req_i & cfg_we_i;
    assign rd_en        = cfg_req_i & ~cfg_we_i;
    // Only the low bits of the write bus feed registers.
    assign unused_wdata = ^cfg_wdata_i;

    // Set conditions: uncorrected disagreement, and any replica rising on is_broken.
    always_comb begin
        uncorr_set = err_detected_i & ~err_corrected_i;
        newbrk_set = '0;
        for (int b = 0; b < N_BLOCKS; b++) begin
            newbrk_set[b] = |(is_broken_i[3*b +: 3] & ~brk_q[3*b +: 3]);
        end
        uncorr_clr = (wr_en && cfg_addr_i == ADDR_UNCORR) ? cfg_wdata_i[N_BLOCKS-1:0] : '0;
        newbrk_clr = (wr_en && cfg_addr_i == ADDR_NEWBRK) ? cfg_wdata_i[N_BLOCKS-1:0] : '0;
    end

    // Control, sticky status, force levels and the previous-cycle broken copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            uncorr_q <= '0;
            newbrk_q <= '0;
            force_q  <= '0;
            brk_q    <= '0;
        end else begin
            if (wr_en && cfg_addr_i == ADDR_CTRL) begin
                ctrl_q <= cfg_wdata_i[1:0];
            end
            if (wr_en && cfg_addr_i == ADDR_FORCE) begin
                force_q <= cfg_wdata_i[3*N_BLOCKS-1:0];
            end
            // Set has priority over a same-cycle W1C clear.
            uncorr_q <= (uncorr_q & ~uncorr_clr) | uncorr_set;
            newbrk_q <= (newbrk_q & ~newbrk_clr) | newbrk_set;
            brk_q    <= is_broken_i;
        end
    end

    genvar gb;
    generate
        for (gb = 0; gb < N_BLOCKS; gb++) begin : g_cnt
            localparam logic [3:0] ADDR_CNT = 4'(8 + gb);
            logic [CNT_W-1:0] cnt_q;
            logic             ev;
            logic             cnt_wr;

            assign ev     = err_detected_i[gb] & ctrl_q[0];
            assign cnt_wr = wr_en && (cfg_addr_i == ADDR_CNT);
            assign cnt_flat[gb*CNT_W +: CNT_W] = cnt_q;

            // Saturating detection counter; a clearing write still counts a same-cycle event.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (cnt_wr) begin
                    cnt_q <= ev ? CNT_W'(1) : '0;
                end else if (ev && cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Read mux over pre-edge state; unmapped addresses return zero.
    always_comb begin
        rdata_d = '0;
        case (cfg_addr_i)
            ADDR_CTRL:   rdata_d[1:0]            = ctrl_q;
            ADDR_UNCORR: rdata_d[N_BLOCKS-1:0]   = uncorr_q;
            ADDR_NEWBRK: rdata_d[N_BLOCKS-1:0]   = newbrk_q;
            ADDR_BROKEN: rdata_d[3*N_BLOCKS-1:0] = is_broken_i;
            ADDR_FORCE:  rdata_d[3*N_BLOCKS-1:0] = force_q;
            default: begin
                if (cfg_addr_i[3]) begin
                    for (int b = 0; b < N_BLOCKS; b++) begin
                        if (cfg_addr_i[2:0] == 3'(b)) begin
                            rdata_d[CNT_W-1:0] = cnt_flat[b*CNT_W +: CNT_W];
                        end
                    end
                end
            end
        endcase
    end

    // Access state register and held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // Every read lands in RESP for one cycle; writes never leave IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = rd_en ? RESP : IDLE;
            RESP:    state_d = rd_en ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cfg_rvalid_o = (state_q == RESP);
    assign cfg_rdata_o  = rdata_q;
    assign set_broken_o = force_q;
    assign irq_o        = ctrl_q[1] & ((|uncorr_q) | (|newbrk_q));

endmodule

// File: tb/tb_cv32e40p_ft_manager.sv
// tb/tb_cv32e40p_ft_manager.sv - directed vector bench for cv32e40p_ft_manager
module tb_cv32e40p_ft_manager;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  det = '0;
    logic [3:0]  cor = '0;
    logic [11:0] brk = '0;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;

    logic [11:0] setb, setb3;
    logic        rvalid, rvalid3;
    logic [31:0] rdata, rdata3;
    logic        irq, irq3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_ft_manager #(.N_BLOCKS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .err_detected_i(det), .err_corrected_i(cor), .is_broken_i(brk),
        .set_broken_o(setb),
        .cfg_req_i(req), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
        .cfg_rvalid_o(rvalid), .cfg_rdata_o(rdata), .irq_o(irq)
    );

    cv32e40p_ft_manager #(.N_BLOCKS(4), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst),
        .err_detected_i(det), .err_corrected_i(cor), .is_broken_i(brk),
        .set_broken_o(setb3),
        .cfg_req_i(req), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
        .cfg_rvalid_o(rvalid3), .cfg_rdata_o(rdata3), .irq_o(irq3)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  det;
        logic [3:0]  cor;
        logic [11:0] brk;
        logic        rv;
        logic [31:0] rdata;
        logic        irq;
        logic [11:0] setb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic w, input logic [3:0] a,
                                input logic [31:0] wd, input logic [3:0] d, input logic [3:0] c,
                                input logic [11:0] b, input logic erv, input logic [31:0] erd,
                                input logic eirq, input logic [11:0] esb);
        vec_t x;
        x.req = r; x.we = w; x.addr = a; x.wdata = wd; x.det = d; x.cor = c; x.brk = b;
        x.rv = erv; x.rdata = erd; x.irq = eirq; x.setb = esb;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic w, input logic [3:0] a, input logic [31:0] wd,
                       input logic [3:0] d, input logic [3:0] c);
        req = r; we = w; addr = a; wdata = wd; det = d; cor = c;
        step();
        req = 1'b0; we = 1'b0; det = '0; cor = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        cyc(1'b1, 1'b1, a, wd, 4'h0, 4'h0);
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'h0, 4'h0, 4'h0);
        chk({nm, " rvalid"}, 32'(rvalid), 32'h1);
        chk(nm, rdata, exp);
    endtask

    initial begin
        // read, write, addr, wdata, det, cor, brk | rvalid, rdata, irq, set_broken
        vt.push_back(mk(1,1,4'h0,32'h3,        4'h0,4'h0,12'h000, 0,32'h0,0,12'h000)); // 0 CTRL=3
        vt.push_back(mk(1,0,4'h0,32'h0,        4'h0,4'h0,12'h000, 1,32'h3,0,12'h000)); // 1 read CTRL
        vt.push_back(mk(1,1,4'h4,32'h00A,      4'h0,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 2 FORCE
        vt.push_back(mk(1,0,4'h4,32'h0,        4'h0,4'h0,12'h000, 1,32'hA,0,12'h00A)); // 3 read FORCE
        vt.push_back(mk(0,0,4'h0,32'h0,        4'h2,4'h0,12'h000, 0,32'h0,1,12'h00A)); // 4 uncorr b1
        vt.push_back(mk(1,0,4'h1,32'h0,        4'h0,4'h0,12'h000, 1,32'h2,1,12'h00A)); // 5 read UNCORR
        vt.push_back(mk(1,1,4'h1,32'h2,        4'h0,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 6 W1C
        vt.push_back(mk(1,1,4'h1,32'h2,        4'h2,4'h0,12'h000, 0,32'h0,1,12'h00A)); // 7 clear vs set
        vt.push_back(mk(1,1,4'h1,32'h0,        4'h0,4'h0,12'h000, 0,32'h0,1,12'h00A)); // 8 write 0 keeps
        vt.push_back(mk(1,0,4'h1,32'h0,        4'h1,4'h0,12'h000, 1,32'h2,1,12'h00A)); // 9 read races set
        vt.push_back(mk(1,1,4'h1,32'hF,        4'h0,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 10 clear all
        vt.push_back(mk(0,0,4'h0,32'h0,        4'h0,4'h0,12'h002, 0,32'h0,1,12'h00A)); // 11 brk rise
        vt.push_back(mk(1,0,4'h2,32'h0,        4'h0,4'h0,12'h002, 1,32'h1,1,12'h00A)); // 12 read NEWBRK
        vt.push_back(mk(1,0,4'h3,32'h0,        4'h0,4'h0,12'h002, 1,32'h2,1,12'h00A)); // 13 read BROKEN
        vt.push_back(mk(1,1,4'h2,32'h1,        4'h0,4'h0,12'h002, 0,32'h0,0,12'h00A)); // 14 W1C held
        vt.push_back(mk(1,0,4'h2,32'h0,        4'h0,4'h0,12'h002, 1,32'h0,0,12'h00A)); // 15 no re-edge
        vt.push_back(mk(0,0,4'h0,32'h0,        4'h0,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 16 brk fall
        vt.push_back(mk(1,1,4'h0,32'h1,        4'h0,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 17 CTRL=1
        vt.push_back(mk(0,0,4'h0,32'h0,        4'h1,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 18 masked irq
        vt.push_back(mk(1,0,4'h1,32'h0,        4'h0,4'h0,12'h000, 1,32'h1,0,12'h00A)); // 19 read UNCORR
        vt.push_back(mk(1,0,4'h5,32'h0,        4'h0,4'h0,12'h000, 1,32'h0,0,12'h00A)); // 20 unmapped rd
        vt.push_back(mk(1,1,4'h5,32'hFFFFFFFF, 4'h0,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 21 unmapped wr
        vt.push_back(mk(1,0,4'h0,32'h0,        4'h0,4'h0,12'h000, 1,32'h1,0,12'h00A)); // 22 read CTRL
        vt.push_back(mk(1,1,4'h0,32'h3,        4'h0,4'h0,12'h000, 0,32'h0,1,12'h00A)); // 23 irq_en on
        vt.push_back(mk(1,1,4'h1,32'hF,        4'h0,4'h0,12'h000, 0,32'h0,0,12'h00A)); // 24 clear
        vt.push_back(mk(1,0,4'h8,32'h0,        4'h0,4'h0,12'h000, 1,32'h2,0,12'h00A)); // 25 DETCNT0
        vt.push_back(mk(1,0,4'h9,32'h0,        4'h0,4'h0,12'h000, 1,32'h2,0,12'h00A)); // 26 DETCNT1
        vt.push_back(mk(1,0,4'hB,32'h0,        4'h0,4'h0,12'h000, 1,32'h0,0,12'h00A)); // 27 DETCNT3

        // Reset state
        step();
        chk("rst set_broken", 32'(setb), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst rvalid", 32'(rvalid), 32'h0);
        chk("rst rdata", rdata, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < vt.size(); i++) begin
            req = vt[i].req; we = vt[i].we; addr = vt[i].addr; wdata = vt[i].wdata;
            det = vt[i].det; cor = vt[i].cor; brk = vt[i].brk;
            step();
            chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vt[i].rv));
            chk($sformatf("vec%0d irq", i), 32'(irq), 32'(vt[i].irq));
            chk($sformatf("vec%0d set_broken", i), 32'(setb), 32'(vt[i].setb));
            if (vt[i].rv) chk($sformatf("vec%0d rdata", i), rdata, vt[i].rdata);
        end
        req = 1'b0; we = 1'b0; det = '0; cor = '0; brk = '0;

        // Counting with corrected errors: no sticky bit, no interrupt
        wr(4'hA, 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h4, 4'h4);
        rd_chk("cnt detcnt2", 4'hA, 32'd5);
        chk("cnt detcnt2 w3", rdata3, 32'd5);
        rd_chk("cnt uncorr", 4'h1, 32'h0);
        chk("cnt irq", 32'(irq), 32'h0);

        // Saturation at 2^CNT_W-1 on the narrow instance
        wr(4'hA, 32'h0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h4, 4'h4);
        rd_chk("sat detcnt2 w16", 4'hA, 32'd10);
        chk("sat detcnt2 w3", rdata3, 32'd7);

        // Clearing write racing an event loads 1
        cyc(1'b1, 1'b1, 4'hA, 32'h0, 4'h4, 4'h4);
        rd_chk("clr+ev w16", 4'hA, 32'd1);
        chk("clr+ev w3", rdata3, 32'd1);
        wr(4'hA, 32'h0);
        rd_chk("clr no ev", 4'hA, 32'd0);

        // Counting disabled
        wr(4'h0, 32'h2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h4, 4'h4);
        rd_chk("cnt_en off", 4'hA, 32'd0);

        // Reset in the middle of a read, with broken replica held across reset
        wr(4'h0, 32'h3);
        wr(4'h4, 32'hFFF);
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h1, 4'h0);
        chk("pre-rst irq", 32'(irq), 32'h1);
        rd_chk("pre-rst ctrl", 4'h0, 32'h3);
        req = 1'b1; we = 1'b0; addr = 4'h0; brk = 12'h100;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst set_broken", 32'(setb), 32'h0);
        chk("async rst irq", 32'(irq), 32'h0);
        chk("async rst rvalid", 32'(rvalid), 32'h0);
        chk("async rst rdata", rdata, 32'h0);
        step();
        chk("rst drops resp", 32'(rvalid), 32'h0);
        req = 1'b0;
        rst = 1'b0;
        step();
        rd_chk("post-rst newbrk", 4'h2, 32'h4);
        rd_chk("post-rst ctrl", 4'h0, 32'h0);
        rd_chk("post-rst force", 4'h4, 32'h0);
        chk("post-rst irq", 32'(irq), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ft_manager.md
# cv32e40p_ft_manager

Central fault-tolerance manager: the responder side of the FT-block status protocol. It gathers `err_detected`, `err_corrected` and `is_broken` from every triplicated block (decoders, ALU, voters) and drives each block's `set_broken` inputs. It keeps saturating error counters and sticky status, raises an interrupt, and exposes everything through a small single-cycle register port. It sits beside the core's FT blocks and is programmed by debug or system software.

## Interface

Parameters:
- `N_BLOCKS`, 4: number of monitored FT blocks; legal range 1..8.
- `CNT_W`, 16: width of each per-block error counter; legal range 1..32.

Ports:

*Clock and reset*
- `clk` in 1: core clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.

*FT block status*
- `err_detected_i` in N_BLOCKS: per-block voter disagreement this cycle.
- `err_corrected_i` in N_BLOCKS: per-block disagreement was outvoted this cycle.
- `is_broken_i` in N_BLOCKS×3: per-block, per-replica broken flag from the breakage monitors.
- `set_broken_o` out N_BLOCKS×3: per-block, per-replica force-broken level.

*Register port*
- `cfg_req_i` in 1: access request.
- `cfg_we_i` in 1: 1 = write, 0 = read.
- `cfg_addr_i` in 4: word address.
- `cfg_wdata_i` in 32: write data.
- `cfg_rvalid_o` out 1: read data valid.
- `cfg_rdata_o` out 32: read data.

*Interrupt*
- `irq_o` out 1: level interrupt.

## Operation

Register map (word addresses); unmapped reads return 0 and unmapped writes are ignored:
- 0x0 CTRL (RW)
  - bit0 `cnt_en`: counters advance only when 1.
  - bit1 `irq_en`.
  - Other bits read 0.
- 0x1 UNCORR (RW1C), bits [N_BLOCKS-1:0]: sticky. Set when `err_detected_i[b] & ~err_corrected_i[b]`.
- 0x2 NEWBRK (RW1C), bits [N_BLOCKS-1:0]: sticky. Set when any replica of block b rises on `is_broken_i` (0→1 versus the registered previous value).
- 0x3 BROKEN (RO): live `is_broken_i`. Block b occupies bits [3b+2:3b].
- 0x4 FORCE (RW), bits [3·N_BLOCKS-1:0]: drives `set_broken_o` directly with the same packing as BROKEN.
- 0x8+b DETCNT[b] (RO, write clears): count of cycles with `err_detected_i[b]=1` while `cnt_en`. Read value is zero-extended to 32 bits.

Counters:
- Saturate at 2^CNT_W−1; no wrap.
- A write to DETCNT[b] in the same cycle as an event loads 1, not 0. Without an event it loads 0.

Sticky bits:
- A W1C clear and a set condition in the same cycle: set wins, bit stays 1.
- Write 0 bits leave the sticky bit unchanged.

Interrupt: `irq_o = irq_en & (|UNCORR | |NEWBRK)`, computed from registered state only.

Broken-edge detection uses a registered copy `brk_q` of `is_broken_i`. After reset `brk_q` = 0, so replicas already broken at the first cycle after reset flag NEWBRK.

Access FSM (two states):
- IDLE: `cfg_req_i` accepted every cycle, no stall.
- Read: goes to RESP, with `cfg_rvalid_o=1` and registered `cfg_rdata_o` in the next cycle. RESP returns to IDLE, or stays in RESP if another read arrives.
- Write: stays in IDLE.

## Timing

- Reset values: CTRL = 0, UNCORR = 0, NEWBRK = 0, FORCE = 0, all counters 0, `brk_q` = 0.
  - Outputs in reset: `set_broken_o` = 0, `irq_o` = 0, `cfg_rvalid_o` = 0, `cfg_rdata_o` = 0.
  - Reset asserted mid-access drops any pending response; no `cfg_rvalid_o` follows.
- Writes take effect on the edge that samples them. FORCE therefore appears on `set_broken_o` one cycle after the request.
- Read latency is exactly 1 cycle. Data reflects state before that edge's updates, so a read racing an event returns the pre-event value.
- A status input at edge k is visible in registers, and on `irq_o`, after edge k. That is one cycle of latency.
- Back-to-back reads are allowed: `cfg_rvalid_o` stays high for consecutive responses.
- `cfg_rdata_o` holds its last value when `cfg_rvalid_o` = 0.

## Test plan

- **Reset:** assert `rst` mid-read → `cfg_rvalid_o` = 0 next cycle. All outputs 0. Reading CTRL after release returns 0.
- **Counting:** CTRL = 1, pulse `err_detected_i[2]` for 5 cycles with `err_corrected_i[2]` = 1 → DETCNT[2] reads 5, UNCORR = 0, `irq_o` = 0.
- **Saturation:**
  - CNT_W = 3: 10 error cycles → DETCNT reads 7.
  - Write DETCNT in a cycle with an event → reads 1.
- **Uncorrected error and interrupt:** CTRL = 3, one cycle of `err_detected_i[1]` = 1 and `err_corrected_i[1]` = 0 → UNCORR = 0x2, `irq_o` = 1 one cycle later.
  - Write UNCORR = 0x2 → `irq_o` = 0 next cycle.
  - Repeat the clear while the error fires in the same cycle → bit stays 1.
- **Broken edge:** raise `is_broken_i[0][1]` → NEWBRK = 0x1, BROKEN bit1 = 1. Holding it high sets no new edge after a W1C clear.
- **Force:** write FORCE = 0x00A → `set_broken_o[0]` = 3'b010, `set_broken_o[1]` = 3'b001, one cycle later. Reading FORCE returns 0x00A.
